// File: rtl/text_buffer_ram.sv
// Character text buffer with a registered read port, an idle-only write port and a
// clear/scroll sweep engine. Define TEXT_BUFFER_SCROLL_EN to enable hardware scrolling.
module text_buffer_ram #(
    parameter int                COL_W  = 4,
    parameter int                ROW_W  = 4,
    parameter int                CODE_W = 7,
    parameter logic [CODE_W-1:0] BLANK  = 7'h20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ROW_W+COL_W-1:0] text_xy,
    output logic [CODE_W-1:0]      char_code,
    input  logic                   wr_en,
    input  logic [ROW_W+COL_W-1:0] wr_xy,
    input  logic [CODE_W-1:0]      wr_code,
    input  logic                   clear_req,
    input  logic                   scroll_req,
    output logic                   busy,
    output logic                   sweep_done
);

    localparam int                ADDR_W    = ROW_W + COL_W;
    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [COL_W-1:0]  LAST_COL  = '1;

`ifdef TEXT_BUFFER_SCROLL_EN
    typedef enum logic [1:0] {IDLE, CLEAR, SCROLL} state_t;
`else
    typedef enum logic [1:0] {IDLE, CLEAR} state_t;
`endif

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   sweep_addr, sweep_addr_nxt;
    logic [ROW_W-1:0]    row_ofs;
    logic [ROW_W-1:0]    rd_row, wr_row;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [CODE_W-1:0]   mem_wdata;
    logic [CODE_W-1:0]   mem [DEPTH];

`ifdef TEXT_BUFFER_SCROLL_EN
    logic [ROW_W-1:0] row_ofs_nxt;
    logic [ROW_W-1:0] scroll_row;

    // The row being blanked is the one that was on top before the offset advanced.
    assign scroll_row = row_ofs - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) row_ofs <= '0;
        else     row_ofs <= row_ofs_nxt;
    end
`else
    logic unused_scroll_req;

    assign row_ofs           = '0;
    assign unused_scroll_req = scroll_req;
`endif

    assign rd_row = text_xy[ADDR_W-1:COL_W] + row_ofs;
    assign wr_row = wr_xy[ADDR_W-1:COL_W] + row_ofs;
    assign busy   = (state != IDLE);

    // NOTE: every signal assigned in this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        sweep_addr_nxt = sweep_addr;
        mem_we         = 1'b0;
        mem_waddr      = sweep_addr;
        mem_wdata      = BLANK;
        sweep_done     = 1'b0;
`ifdef TEXT_BUFFER_SCROLL_EN
        row_ofs_nxt    = row_ofs;
`endif
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nxt      = CLEAR;
                    sweep_addr_nxt = '0;
                end
`ifdef TEXT_BUFFER_SCROLL_EN
                else if (scroll_req) begin
                    state_nxt      = SCROLL;
                    sweep_addr_nxt = '0;
                    row_ofs_nxt    = row_ofs + 1'b1;
                end
`endif
                else if (wr_en) begin
                    mem_we    = 1'b1;
                    mem_waddr = {wr_row, wr_xy[COL_W-1:0]};
                    mem_wdata = wr_code;
                end
            end
            CLEAR: begin
                mem_we         = 1'b1;
                sweep_addr_nxt = sweep_addr + 1'b1;
                if (sweep_addr == LAST_ADDR) begin
                    sweep_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
`ifdef TEXT_BUFFER_SCROLL_EN
            SCROLL: begin
                mem_we         = 1'b1;
                mem_waddr      = {scroll_row, sweep_addr[COL_W-1:0]};
                sweep_addr_nxt = sweep_addr + 1'b1;
                if (sweep_addr[COL_W-1:0] == LAST_COL) begin
                    sweep_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            sweep_addr <= '0;
        end else begin
            state      <= state_nxt;
            sweep_addr <= sweep_addr_nxt;
        end
    end

    // NOTE: the storage array has no reset so it maps onto RAM; the post-reset CLEAR sweep initialises it.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
    end

    // Read sees the pre-write contents when both ports hit the same address.
    always_ff @(posedge clk) begin
        if (rst) char_code <= BLANK;
        else     char_code <= mem[{rd_row, text_xy[COL_W-1:0]}];
    end

endmodule

// File: tb/tb_text_buffer_ram.sv
// Randomised self-checking bench for text_buffer_ram (default parameters) against an
// array-based model of the buffer; scroll scenarios run when TEXT_BUFFER_SCROLL_EN is defined.
module tb_text_buffer_ram;

    localparam logic [6:0] BLANK = 7'h20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] text_xy = '0;
    logic [6:0] char_code;
    logic       wr_en = 1'b0;
    logic [7:0] wr_xy = '0;
    logic [6:0] wr_code = '0;
    logic       clear_req = 1'b0;
    logic       scroll_req = 1'b0;
    logic       busy;
    logic       sweep_done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    text_buffer_ram dut (
        .clk(clk), .rst(rst), .text_xy(text_xy), .char_code(char_code),
        .wr_en(wr_en), .wr_xy(wr_xy), .wr_code(wr_code),
        .clear_req(clear_req), .scroll_req(scroll_req),
        .busy(busy), .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: physical buffer contents (-1 = never written), row offset and sweep progress.
    int mm [256];
    int m_ofs = 0;
    int m_mode = 0;   // 0 idle, 1 clearing, 2 scrolling
    int m_pos = 0;
    int exp_code = -1;
    bit exp_busy = 1'b0;
    bit exp_done = 1'b0;

    function automatic int phys(input logic [7:0] xy);
        return ((((int'(xy) / 16) + m_ofs) % 16) * 16) + (int'(xy) % 16);
    endfunction

    initial foreach (mm[i]) mm[i] = -1;

    always @(posedge clk) begin
        if (rst) begin
            exp_code = int'(BLANK);
            m_mode   = 1;
            m_pos    = 0;
            m_ofs    = 0;
        end else begin
            exp_code = mm[phys(text_xy)];
            case (m_mode)
                0: begin
                    if (clear_req) begin
                        m_mode = 1;
                        m_pos  = 0;
                    end
`ifdef TEXT_BUFFER_SCROLL_EN
                    else if (scroll_req) begin
                        m_ofs  = (m_ofs + 1) % 16;
                        m_mode = 2;
                        m_pos  = 0;
                    end
`endif
                    else if (wr_en) mm[phys(wr_xy)] = int'(wr_code);
                end
                1: begin
                    mm[m_pos] = int'(BLANK);
                    m_pos++;
                    if (m_pos == 256) m_mode = 0;
                end
                default: begin
                    mm[((m_ofs + 15) % 16) * 16 + m_pos] = int'(BLANK);
                    m_pos++;
                    if (m_pos == 16) m_mode = 0;
                end
            endcase
        end
        exp_busy = (m_mode != 0);
        exp_done = (m_mode == 1 && m_pos == 255) || (m_mode == 2 && m_pos == 15);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, exp_busy);
            check("sweep_done", sweep_done, exp_done);
            if (exp_code >= 0) check("char_code", char_code, exp_code);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts busy cycles from now until busy falls; records the busy cycle carrying sweep_done.
    task automatic run_sweep(output int busy_cycles, output int done_at, output int done_cnt);
        busy_cycles = 0;
        done_at     = -1;
        done_cnt    = 0;
        while (busy === 1'b1 && busy_cycles < 2000) begin
            busy_cycles++;
            if (sweep_done === 1'b1) begin
                done_cnt++;
                done_at = busy_cycles;
            end
            step();
        end
        if (busy_cycles >= 2000) check("sweep_timeout", busy_cycles, 0);
    endtask

    task automatic read_at(input logic [7:0] xy, input logic [6:0] exp, input string name);
        text_xy = xy;
        step();
        check(name, char_code, exp);
    endtask

    task automatic write_at(input logic [7:0] xy, input logic [6:0] code);
        wr_en   = 1'b1;
        wr_xy   = xy;
        wr_code = code;
        step();
        wr_en = 1'b0;
    endtask

    int n_busy, n_done_at, n_done;

    initial begin
        repeat (3) step();
        check("rst_busy", busy, 1);
        check("rst_sweep_done", sweep_done, 0);
        check("rst_char_code", char_code, 7'h20);
        chk_en = 1'b1;

        // Post-reset clear runs by itself.
        rst = 1'b0;
        run_sweep(n_busy, n_done_at, n_done);
        check("init_busy_cycles", n_busy, 256);
        check("init_done_at", n_done_at, 256);
        check("init_done_count", n_done, 1);
        for (int i = 0; i < 256; i++) read_at(8'(i), 7'h20, "init_blank");

        // Idle write then read with latency 1.
        text_xy = 8'h33;
        write_at(8'h00, 7'h56);
        read_at(8'h00, 7'h56, "write_read_00");

        // Same-address read and write return the old contents.
        text_xy = 8'h07;
        write_at(8'h07, 7'h11);
        check("rbw_old", char_code, 7'h20);
        step();
        check("rbw_new", char_code, 7'h11);

        // Writes during a clear sweep are dropped.
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        write_at(8'h05, 7'h2D);
        run_sweep(n_busy, n_done_at, n_done);
        check("clear_rest_cycles", n_busy, 255);
        read_at(8'h05, 7'h20, "dropped_write");
        read_at(8'h00, 7'h20, "cleared_00");

`ifdef TEXT_BUFFER_SCROLL_EN
        // One scroll: logical row 1 moves to row 0, bottom row is blank.
        write_at(8'h10, 7'h41);
        scroll_req = 1'b1;
        step();
        scroll_req = 1'b0;
        run_sweep(n_busy, n_done_at, n_done);
        check("scroll_busy_cycles", n_busy, 16);
        check("scroll_done_at", n_done_at, 16);
        read_at(8'h00, 7'h41, "scroll_row0");
        read_at(8'hF0, 7'h20, "scroll_row15");

        // Fifteen more scrolls bring the offset back to zero.
        for (int s = 0; s < 15; s++) begin
            scroll_req = 1'b1;
            step();
            scroll_req = 1'b0;
            run_sweep(n_busy, n_done_at, n_done);
            check("scroll_n_cycles", n_busy, 16);
        end
        write_at(8'h00, 7'h52);
        read_at(8'h00, 7'h52, "wrap_row0");
        read_at(8'h10, 7'h20, "wrap_row1_blanked");
`else
        // Scroll requests are ignored; a simultaneous write still lands.
        scroll_req = 1'b1;
        wr_en      = 1'b1;
        wr_xy      = 8'h10;
        wr_code    = 7'h41;
        step();
        scroll_req = 1'b0;
        wr_en      = 1'b0;
        check("scroll_ignored_busy", busy, 0);
        read_at(8'h10, 7'h41, "scroll_ignored_write");
`endif

        // Clear wins over scroll; row offset is untouched.
        write_at(8'h10, 7'h4A);
        clear_req  = 1'b1;
        scroll_req = 1'b1;
        step();
        clear_req  = 1'b0;
        scroll_req = 1'b0;
        run_sweep(n_busy, n_done_at, n_done);
        check("clr_scr_cycles", n_busy, 256);
        write_at(8'h10, 7'h4B);
        read_at(8'h10, 7'h4B, "clr_scr_mapping");

        // Reset 100 cycles into a sweep restarts the full clear.
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (99) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_char_code", char_code, 7'h20);
        run_sweep(n_busy, n_done_at, n_done);
        check("midrst_cycles", n_busy, 256);
        check("midrst_done_at", n_done_at, 256);

        // Random traffic; the compare process checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            text_xy    = 8'($urandom_range(0, 255));
            wr_en      = ($urandom_range(0, 3) != 0);
            wr_xy      = 8'($urandom_range(0, 255));
            wr_code    = 7'($urandom_range(0, 127));
            clear_req  = ($urandom_range(0, 299) == 0);
            scroll_req = ($urandom_range(0, 39) == 0);
            step();
        end
        wr_en      = 1'b0;
        clear_req  = 1'b0;
        scroll_req = 1'b0;
        run_sweep(n_busy, n_done_at, n_done);
        for (int i = 0; i < 256; i += 17) begin
            text_xy = 8'(i);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_buffer_ram.md
TEXT_BUFFER_RAM -- requirements
Module: text_buffer_ram

Interface
REQ-001 SHALL have parameter COL_W, default 4, column address width (2^COL_W columns per row).
REQ-002 SHALL have parameter ROW_W, default 4, row address width (2^ROW_W rows).
REQ-003 SHALL have parameter CODE_W, default 7, character code width.
REQ-004 SHALL have parameter BLANK, default 7'h20, fill code written by clear and scroll sweeps.
REQ-005 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port text_xy  input  ROW_W+COL_W  read address {row,col}, logical coordinates.
REQ-008 SHALL have port char_code  output  CODE_W  registered read data.
REQ-009 SHALL have port wr_en  input  1  write strobe.
REQ-010 SHALL have port wr_xy  input  ROW_W+COL_W  write address {row,col}, logical.
REQ-011 SHALL have port wr_code  input  CODE_W  write data.
REQ-012 SHALL have port clear_req  input  1  single-cycle request to blank the whole buffer.
REQ-013 SHALL have port scroll_req  input  1  single-cycle request to scroll up one row.
REQ-014 SHALL have port busy  output  1  high while a clear or scroll sweep runs.
REQ-015 SHALL have port sweep_done  output  1  one-cycle pulse on the last sweep write.

Function
REQ-016 SHALL store 2^(ROW_W+COL_W) entries of CODE_W bits, inferable as block or distributed RAM.
REQ-017 SHALL map logical row r to physical row (r + row_ofs) mod 2^ROW_W for reads and writes; column unchanged.
REQ-018 SHALL present char_code one cycle after text_xy (latency 1); reads stay valid while busy.
REQ-019 SHALL return old data (read-before-write) when read and write hit the same physical address in one cycle.
REQ-020 SHALL write wr_code when wr_en=1 and FSM is IDLE; writes while busy are dropped, not queued.
REQ-021 SHALL use FSM states IDLE, CLEAR, SCROLL.
REQ-022 IDLE -> CLEAR on clear_req: write BLANK to physical addresses 0..2^(ROW_W+COL_W)-1, one per cycle, ascending.
REQ-023 IDLE -> SCROLL on scroll_req: row_ofs increments (wraps 2^ROW_W-1 -> 0); physical row equal to old row_ofs written with BLANK, columns 0..2^COL_W-1, one per cycle.
REQ-024 CLEAR/SCROLL -> IDLE after final address; sweep_done pulses that cycle; busy falls the next cycle.
REQ-025 SHALL give priority clear_req > scroll_req > wr_en when asserted together in IDLE; losers dropped.
REQ-026 SHALL ignore clear_req and scroll_req while busy.
REQ-027 CLEAR sweep SHALL NOT alter row_ofs.

Reset
REQ-028 rst SHALL force FSM to CLEAR at address 0, row_ofs=0, busy=1, sweep_done=0, char_code=BLANK.
REQ-029 rst asserted mid-sweep SHALL abandon the sweep and restart full CLEAR from address 0.
REQ-030 Buffer SHALL be fully BLANK 2^(ROW_W+COL_W) cycles after rst deasserts, with no external request.

Configuration
REQ-031 Macro TEXT_BUFFER_SCROLL_EN defined: SCROLL state, row_ofs and translation per REQ-017/023 present.
REQ-032 Macro undefined: no SCROLL state, row_ofs constant 0, scroll_req ignored, logical = physical addressing.

Verification
REQ-033 Reset released, defaults -> busy high 256 cycles, sweep_done pulse at cycle 256; every address then reads 7'h20.
REQ-034 Write 7'h56 at 8'h00 while idle; read 8'h00 -> char_code 7'h56 exactly one cycle after address applied.
REQ-035 wr_en at 8'h05 with 7'h2D during CLEAR -> after sweep, 8'h05 reads 7'h20 (write dropped).
REQ-036 SCROLL_EN: write 7'h41 at 8'h10, scroll_req -> busy 16 cycles; 8'h00 reads 7'h41, 8'hF0 reads 7'h20.
REQ-037 SCROLL_EN: 16 scroll_req pulses (each after busy falls) -> row_ofs wraps to 0; idle written data at row 0 unchanged unless blanked.
REQ-038 clear_req and scroll_req same cycle -> full 256-cycle CLEAR, row_ofs unchanged; rst at cycle 100 of sweep -> restart, 256 further cycles.
